// File: rtl/bus_hub_if.sv
// Core-side and slave-side bus signals of the memory interconnect.
// The slave modport is the hub's view, and the master modport is the environment's view.
interface bus_hub_if;
  logic [31:0]  a;
  logic [31:0]  d;
  logic         we;
  logic         rd;
  logic [31:0]  spo;
  logic         ready;
  logic [31:0]  s_a;
  logic [31:0]  s_d;
  logic [3:0]   s_we;
  logic [3:0]   s_rd;
  logic [127:0] s_spo;
  logic [3:0]   s_ready;
  logic         bus_err;
  logic [31:0]  err_addr;

  modport slave (
    input  a, d, we, rd, s_spo, s_ready,
    output spo, ready, s_a, s_d, s_we, s_rd, bus_err, err_addr
  );

  modport master (
    output a, d, we, rd, s_spo, s_ready,
    input  spo, ready, s_a, s_d, s_we, s_rd, bus_err, err_addr
  );
endinterface

// File: rtl/bus_hub.sv
// Four-region interconnect behind the core memory port. It issues a one-cycle slave strobe
// and finishes every request with ready, using an all-ones error on unmapped accesses or timeout.
//
// state   | meaning
// IDLE    | accepts rd/we; decodes, strobes, and may complete in the same cycle
// WAIT    | holds latched addr/wdata and waits for s_ready[sel] or the timeout
module bus_hub #(
  parameter logic [31:0] BASE0   = 32'h0000_0000,
  parameter logic [31:0] BASE1   = 32'h2000_0000,
  parameter logic [31:0] BASE2   = 32'h9000_0000,
  parameter logic [31:0] BASE3   = 32'hf000_0000,
  parameter logic [31:0] MASK0   = 32'hf000_0000,
  parameter logic [31:0] MASK1   = 32'hf000_0000,
  parameter logic [31:0] MASK2   = 32'hf000_0000,
  parameter logic [31:0] MASK3   = 32'hf000_0000,
  parameter int          TIMEOUT = 255
) (
  input  logic     clk,
  input  logic     rst,
  bus_hub_if.slave bus
);
  localparam int            CW       = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state_q, state_n;
  logic [31:0]   addr_q, addr_n;
  logic [31:0]   wdata_q, wdata_n;
  logic [31:0]   err_addr_q, err_addr_n;
  logic [1:0]    sel_q, sel_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [1:0]    dec_sel;
  logic          dec_hit;
  logic          req;

  assign req          = bus.rd | bus.we;
  assign bus.err_addr = err_addr_q;

  // Priority decode: the lowest index wins when regions overlap.
  always_comb begin
    dec_hit = 1'b1;
    dec_sel = 2'd0;
    if ((bus.a & MASK0) == BASE0)      dec_sel = 2'd0;
    else if ((bus.a & MASK1) == BASE1) dec_sel = 2'd1;
    else if ((bus.a & MASK2) == BASE2) dec_sel = 2'd2;
    else if ((bus.a & MASK3) == BASE3) dec_sel = 2'd3;
    else                               dec_hit = 1'b0;
  end

  // The read/write direction only affects the strobe cycle, so it is not latched.
  always_comb begin
    state_n     = state_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    sel_n       = sel_q;
    cnt_n       = cnt_q;
    err_addr_n  = err_addr_q;
    bus.ready   = 1'b0;
    bus.spo     = 32'h0;
    bus.bus_err = 1'b0;
    bus.s_we    = 4'b0000;
    bus.s_rd    = 4'b0000;
    bus.s_a     = bus.a;
    bus.s_d     = bus.d;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (dec_hit) begin
            bus.s_we[dec_sel] = bus.we;
            bus.s_rd[dec_sel] = bus.rd & ~bus.we;
            addr_n  = bus.a;
            wdata_n = bus.d;
            sel_n   = dec_sel;
            if (bus.s_ready[dec_sel]) begin
              bus.ready = 1'b1;
              bus.spo   = bus.s_spo[{dec_sel, 5'd0} +: 32];
            end else begin
              state_n = ST_WAIT;
              cnt_n   = '0;
            end
          end else begin
            bus.ready   = 1'b1;
            bus.spo     = 32'hffff_ffff;
            bus.bus_err = 1'b1;
            err_addr_n  = bus.a;
          end
        end
      end
      ST_WAIT: begin
        bus.s_a = addr_q;
        bus.s_d = wdata_q;
        if (bus.s_ready[sel_q]) begin
          bus.ready = 1'b1;
          bus.spo   = bus.s_spo[{sel_q, 5'd0} +: 32];
          state_n   = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          bus.ready   = 1'b1;
          bus.spo     = 32'hffff_ffff;
          bus.bus_err = 1'b1;
          err_addr_n  = addr_q;
          state_n     = ST_IDLE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      err_addr_q <= 32'h0;
      sel_q      <= 2'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      err_addr_q <= err_addr_n;
      sel_q      <= sel_n;
      cnt_q      <= cnt_n;
    end
  end
endmodule

// File: tb/tb_bus_hub.sv
// Randomized scoreboard bench for bus_hub: the driver queues expected completions,
// and a negedge monitor pops and compares them whenever ready rises.
module tb_bus_hub;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_hub_if bus_a ();
  bus_hub_if bus_b ();

  bus_hub #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus_a));
  bus_hub #(.BASE1(32'h0000_0000), .MASK1(32'hf000_0000), .TIMEOUT(TO))
    dut_ovl (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    int unsigned cyc;
    logic [31:0] spo;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  logic        mon_en   = 1'b0;
  logic [31:0] exp_sa   = '0;
  logic [31:0] exp_sd   = '0;
  logic [3:0]  exp_we   = '0;
  logic [3:0]  exp_rd   = '0;
  logic [31:0] model_ea = '0;

  localparam logic [31:0] BASE_M [4] = '{32'h0000_0000, 32'h2000_0000, 32'h9000_0000, 32'hf000_0000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int decode(input logic [31:0] addr);
    for (int n = 0; n < 4; n++)
      if ((addr & 32'hf000_0000) == BASE_M[n]) return n;
    return -1;
  endfunction

  function automatic logic [3:0] noise(input int sel);
    logic [3:0] n;
    n = 4'($urandom);
    if (sel >= 0) n[sel] = 1'b0;
    return n;
  endfunction

  // Monitor: checks the shared slave bus every cycle and the response when ready rises.
  always @(negedge clk) begin
    exp_t it;
    if (mon_en) begin
      chk("err_addr", bus_a.err_addr, model_ea);
      if (rst) begin
        model_ea = '0;
      end else begin
        chk("s_we", {28'h0, bus_a.s_we}, {28'h0, exp_we});
        chk("s_rd", {28'h0, bus_a.s_rd}, {28'h0, exp_rd});
        chk("s_a", bus_a.s_a, exp_sa);
        chk("s_d", bus_a.s_d, exp_sd);
        if (bus_a.ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_ready actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            it = exp_q.pop_front();
            chk("ready_cycle", cyc, it.cyc);
            chk("spo", bus_a.spo, it.spo);
            chk("bus_err", {31'h0, bus_a.bus_err}, {31'h0, it.err});
            if (it.err) model_ea = it.addr;
          end
        end else begin
          chk("spo_idle", bus_a.spo, 32'h0);
          chk("bus_err_idle", {31'h0, bus_a.bus_err}, 32'h0);
        end
      end
    end
  end

  // op: 0 read, 1 write, 2 both (treated as write); k: slave answer cycle, >TO means never.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wd, input int op,
                        input int k, input logic [127:0] lanes);
    int   sel;
    int   e;
    exp_t it;
    sel     = decode(addr);
    it.addr = addr;
    if (sel < 0) begin
      e = 0; it.spo = 32'hffff_ffff; it.err = 1'b1;
    end else if (k <= TO) begin
      e = k; it.spo = lanes[sel*32 +: 32]; it.err = 1'b0;
    end else begin
      e = TO; it.spo = 32'hffff_ffff; it.err = 1'b1;
    end
    @(posedge clk); #1;
    it.cyc = cyc + e;
    exp_q.push_back(it);
    bus_a.a     = addr;
    bus_a.d     = wd;
    bus_a.rd    = (op != 1);
    bus_a.we    = (op != 0);
    bus_a.s_spo = lanes;
    exp_sa      = addr;
    exp_sd      = wd;
    exp_we      = (sel >= 0 && op != 0) ? 4'(1 << sel) : 4'b0000;
    exp_rd      = (sel >= 0 && op == 0) ? 4'(1 << sel) : 4'b0000;
    for (int c = 0; c <= e; c++) begin
      if (c > 0) begin
        bus_a.rd = 1'b0; bus_a.we = 1'b0;
        bus_a.a  = $urandom; bus_a.d = $urandom;
        exp_we   = '0; exp_rd = '0;
      end
      bus_a.s_ready = noise(sel) | ((sel >= 0 && c == k) ? 4'(1 << sel) : 4'b0000);
      @(posedge clk); #1;
    end
    bus_a.rd = 1'b0; bus_a.we = 1'b0;
    bus_a.a  = $urandom; bus_a.d = $urandom;
    exp_sa   = bus_a.a; exp_sd = bus_a.d;
    exp_we   = '0; exp_rd = '0;
    bus_a.s_ready = 4'($urandom);
  endtask

  initial begin
    logic [31:0]  addr;
    logic [3:0]   nib;
    logic [127:0] lanes;
    bus_a.a = '0; bus_a.d = '0; bus_a.rd = 1'b0; bus_a.we = 1'b0;
    bus_a.s_spo = '0; bus_a.s_ready = '0;
    bus_b.a = '0; bus_b.d = '0; bus_b.rd = 1'b0; bus_b.we = 1'b0;
    bus_b.s_spo = '0; bus_b.s_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_sa = bus_a.a; exp_sd = bus_a.d;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Directed cases: combinational slave 3, slave 1 after 3 cycles, unmapped, timeout.
    do_req(32'hf000_0010, 32'h0, 0, 0, {32'h1234_5678, 96'h0});
    do_req(32'h2000_0004, 32'hdead_beef, 1, 3, {$urandom, $urandom, $urandom, $urandom});
    do_req(32'h5000_0000, 32'h0, 0, 0, {$urandom, $urandom, $urandom, $urandom});
    do_req(32'h0000_0100, 32'h0, 0, TO + 5, {$urandom, $urandom, $urandom, $urandom});
    do_req(32'h9000_0008, 32'h0, 0, TO, {$urandom, $urandom, $urandom, $urandom});

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) nib = 4'($urandom);
      else case ($urandom_range(0, 3))
        0: nib = 4'h0;
        1: nib = 4'h2;
        2: nib = 4'h9;
        default: nib = 4'hf;
      endcase
      addr  = {nib, 28'($urandom)};
      lanes = {$urandom, $urandom, $urandom, $urandom};
      do_req(addr, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, TO + 2)), lanes);
    end

    // rst two cycles into WAIT on slave 2; the late answer must not produce ready.
    do_req(32'h7000_0000, 32'h0, 0, 0, '0);
    @(posedge clk); #1;
    bus_a.a = 32'h9000_0040; bus_a.rd = 1'b1; bus_a.s_ready = 4'b0000;
    exp_sa = bus_a.a; exp_sd = bus_a.d; exp_rd = 4'b0100;
    @(posedge clk); #1;
    bus_a.rd = 1'b0; bus_a.a = $urandom; exp_rd = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_a.s_ready = 4'b0100;
    exp_sa = bus_a.a; exp_sd = bus_a.d;
    do_req(32'h9000_0000, 32'h0, 0, 0, {$urandom, $urandom, $urandom, $urandom});
    @(posedge clk); #1;

    // Overlapping regions 0 and 1: only slave 0 is strobed, and region 1's old range is unmapped.
    bus_b.a = 32'h0; bus_b.rd = 1'b1; bus_b.s_ready = 4'b0011;
    bus_b.s_spo = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    @(negedge clk);
    chk("ovl_s_rd", {28'h0, bus_b.s_rd}, 32'h1);
    chk("ovl_ready", {31'h0, bus_b.ready}, 32'h1);
    chk("ovl_spo", bus_b.spo, 32'h1111_1111);
    @(posedge clk); #1;
    bus_b.a = 32'h2000_0000;
    @(negedge clk);
    chk("ovl_unmapped_s_rd", {28'h0, bus_b.s_rd}, 32'h0);
    chk("ovl_unmapped_spo", bus_b.spo, 32'hffff_ffff);
    chk("ovl_unmapped_err", {31'h0, bus_b.bus_err}, 32'h1);
    @(posedge clk); #1;
    bus_b.rd = 1'b0;
    @(negedge clk);
    chk("ovl_err_addr", bus_b.err_addr, 32'h2000_0000);
    chk("ovl_idle_ready", {31'h0, bus_b.ready}, 32'h0);

    repeat (2) @(posedge clk);
    chk("pending_expect", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
